// File: rtl/ocp_master_port_pkg.sv
// Shared widths, OCP command/response codes and FSM state type for ocp_master_port.
package ocp_master_port_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = DATA_WIDTH / 8;

    localparam logic [2:0] MCMD_IDLE = 3'd0;
    localparam logic [2:0] MCMD_WR   = 3'd1;
    localparam logic [2:0] MCMD_RD   = 3'd2;

    localparam logic [1:0] SRESP_NULL = 2'd0;
    localparam logic [1:0] SRESP_DVA  = 2'd1;
    localparam logic [1:0] SRESP_FAIL = 2'd2;
    localparam logic [1:0] SRESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/ocp_master_port_wdt.sv
// Transaction watchdog: 16-bit cycle counter with expiry compare, used only when
// OCP_MASTER_TIMEOUT_EN is defined.
module ocp_master_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    // Expiry is flagged in the last allowed cycle so the abort edge lands exactly
    // TIMEOUT_CYCLES cycles after command entry.
    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_run && (cnt_q == LAST_CYCLE);

endmodule

// File: rtl/ocp_master_port.sv
// OCP initiator: one outstanding read/write per client request, response returned to the client.
// Optional command-to-response watchdog enabled by defining OCP_MASTER_TIMEOUT_EN.
module ocp_master_port
    import ocp_master_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    // Client request/response: a transfer happens on an edge where valid && ready;
    // valid is held with stable payload until then, ready never depends on valid.
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic [BEN_WIDTH-1:0]  i_req_ben,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_rsp_tmo,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp,
    output state_t                o_dbg_state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ocp_master_port: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BEN_WIDTH-1:0]  ben_q, ben_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_tmo_q, rsp_tmo_d;
    logic                  tmo_expired;

`ifdef OCP_MASTER_TIMEOUT_EN
    logic wdt_clear;
    logic wdt_run;

    assign wdt_clear = (state_q == ST_IDLE) && i_req_valid;
    assign wdt_run   = (state_q == ST_CMD) || (state_q == ST_WAIT);

    ocp_master_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (wdt_clear),
        .i_run     (wdt_run),
        .o_expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ben_d      = ben_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_tmo_d  = rsp_tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    data_d  = i_req_data;
                    ben_d   = i_req_ben;
                    state_d = ST_CMD;
                end
            end
            ST_CMD, ST_WAIT: begin
                // A real response always beats a watchdog expiry in the same cycle.
                if ((i_SResp != SRESP_NULL) && (i_SCmdAccept || (state_q == ST_WAIT))) begin
                    rsp_err_d  = (i_SResp != SRESP_DVA);
                    rsp_data_d = (!we_q && (i_SResp == SRESP_DVA)) ? i_SData : '0;
                    rsp_tmo_d  = 1'b0;
                    state_d    = ST_RSP;
                end else if (tmo_expired) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    rsp_tmo_d  = 1'b1;
                    state_d    = ST_RSP;
                end else if (i_SCmdAccept && (state_q == ST_CMD)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ben_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ben_q      <= ben_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RSP);
    assign o_rsp_data  = o_rsp_valid ? rsp_data_q : '0;
    assign o_rsp_err   = o_rsp_valid && rsp_err_q;
    assign o_rsp_tmo   = o_rsp_valid && rsp_tmo_q;
    assign o_dbg_state = state_q;

    // Master request fields are only non-zero while the command is on the bus.
    always_comb begin
        o_MCmd    = MCMD_IDLE;
        o_MAddr   = '0;
        o_MData   = '0;
        o_MByteEn = '0;
        if (state_q == ST_CMD) begin
            o_MCmd    = we_q ? MCMD_WR : MCMD_RD;
            o_MAddr   = addr_q;
            o_MData   = data_q;
            o_MByteEn = ben_q;
        end
    end

endmodule

// File: tb/tb_ocp_master_port.sv
// Self-checking bench for ocp_master_port: directed scenarios plus randomized
// transactions scored against a response model; timeout scenario follows OCP_MASTER_TIMEOUT_EN.
module tb_ocp_master_port;
    import ocp_master_port_pkg::*;

    localparam int TMO = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_req_valid = 1'b0;
    logic                  o_req_ready;
    logic                  i_req_we = 1'b0;
    logic [ADDR_WIDTH-1:0] i_req_addr = '0;
    logic [DATA_WIDTH-1:0] i_req_data = '0;
    logic [BEN_WIDTH-1:0]  i_req_ben = '0;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready = 1'b0;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_rsp_err;
    logic                  o_rsp_tmo;
    logic [ADDR_WIDTH-1:0] o_MAddr;
    logic [2:0]            o_MCmd;
    logic [DATA_WIDTH-1:0] o_MData;
    logic [BEN_WIDTH-1:0]  o_MByteEn;
    logic                  i_SCmdAccept = 1'b0;
    logic [DATA_WIDTH-1:0] i_SData = '0;
    logic [1:0]            i_SResp = SRESP_NULL;
    state_t                o_dbg_state;

    int checks   = 0;
    int failures = 0;

    // scoreboard entries: {err, data}
    logic [DATA_WIDTH:0] exp_q[$];

    ocp_master_port #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_data   (i_req_data),
        .i_req_ben    (i_req_ben),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_tmo    (o_rsp_tmo),
        .o_MAddr      (o_MAddr),
        .o_MCmd       (o_MCmd),
        .o_MData      (o_MData),
        .o_MByteEn    (o_MByteEn),
        .i_SCmdAccept (i_SCmdAccept),
        .i_SData      (i_SData),
        .i_SResp      (i_SResp),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},     64'(o_dbg_state), 64'(ST_IDLE));
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(o_rsp_data),  64'd0);
        check({tag, "_rsp_err"},   64'(o_rsp_err),   64'd0);
        check({tag, "_rsp_tmo"},   64'(o_rsp_tmo),   64'd0);
        check({tag, "_mcmd"},      64'(o_MCmd),      64'(MCMD_IDLE));
        check({tag, "_maddr"},     64'(o_MAddr),     64'd0);
        check({tag, "_mdata"},     64'(o_MData),     64'd0);
        check({tag, "_mben"},      64'(o_MByteEn),   64'd0);
    endtask

    // Reference: error unless DVA; data only for a successful read.
    function automatic logic [DATA_WIDTH:0] model_rsp(input logic we, input logic [1:0] resp,
                                                      input logic [DATA_WIDTH-1:0] sdata);
        logic err;
        err = (resp != SRESP_DVA);
        return {err, (we || err) ? {DATA_WIDTH{1'b0}} : sdata};
    endfunction

    // ---------------- driver ----------------
    // acc_dly: CMD cycles before the accept cycle; rsp_dly: cycles from accept to response
    // (0 = same cycle); hold: cycles of i_rsp_ready low once the response is valid.
    task automatic run_txn(input string tag, input logic we, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [DATA_WIDTH-1:0] data, input logic [BEN_WIDTH-1:0] ben,
                           input int acc_dly, input int rsp_dly, input logic [1:0] resp,
                           input logic [DATA_WIDTH-1:0] sdata, input int hold);
        logic [2:0]          exp_cmd;
        logic [DATA_WIDTH:0] exp;
        exp_cmd = we ? MCMD_WR : MCMD_RD;
        exp_q.push_back(model_rsp(we, resp, sdata));
        check({tag, "_ready_before"}, 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_data  = data;
        i_req_ben   = ben;
        step();
        i_req_valid = 1'b0;
        i_req_we    = 1'($urandom);
        i_req_addr  = $urandom;
        i_req_data  = $urandom;
        i_req_ben   = 4'($urandom);
        for (int i = 0; i <= acc_dly; i++) begin
            check({tag, "_cmd"},       64'(o_MCmd),      64'(exp_cmd));
            check({tag, "_cmd_addr"},  64'(o_MAddr),     64'(addr));
            check({tag, "_cmd_data"},  64'(o_MData),     64'(data));
            check({tag, "_cmd_ben"},   64'(o_MByteEn),   64'(ben));
            check({tag, "_cmd_ready"}, 64'(o_req_ready), 64'd0);
            check({tag, "_cmd_rspv"},  64'(o_rsp_valid), 64'd0);
            if (i == acc_dly) begin
                i_SCmdAccept = 1'b1;
                i_SResp      = (rsp_dly == 0) ? resp : SRESP_NULL;
                i_SData      = sdata;
            end else begin
                i_SCmdAccept = 1'b0;
                i_SResp      = 2'($urandom_range(0, 3));
                i_SData      = $urandom;
            end
            step();
        end
        i_SCmdAccept = 1'b0;
        i_SResp      = SRESP_NULL;
        i_SData      = $urandom;
        for (int j = 1; j <= rsp_dly; j++) begin
            check({tag, "_wait_cmd"},   64'(o_MCmd),      64'(MCMD_IDLE));
            check({tag, "_wait_addr"},  64'(o_MAddr),     64'd0);
            check({tag, "_wait_rspv"},  64'(o_rsp_valid), 64'd0);
            check({tag, "_wait_ready"}, 64'(o_req_ready), 64'd0);
            if (j == rsp_dly) begin
                i_SResp = resp;
                i_SData = sdata;
            end
            step();
            i_SResp = SRESP_NULL;
            i_SData = $urandom;
        end
        exp = exp_q[0];
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd1);
            check({tag, "_rsp_data"},  64'(o_rsp_data),  64'(exp[DATA_WIDTH-1:0]));
            check({tag, "_rsp_err"},   64'(o_rsp_err),   64'(exp[DATA_WIDTH]));
            check({tag, "_rsp_tmo"},   64'(o_rsp_tmo),   64'd0);
            check({tag, "_rsp_ready"}, 64'(o_req_ready), 64'd0);
            check({tag, "_rsp_mcmd"},  64'(o_MCmd),      64'(MCMD_IDLE));
            i_SResp     = 2'($urandom_range(0, 3));
            i_SData     = $urandom;
            i_rsp_ready = (h == hold);
            step();
        end
        void'(exp_q.pop_front());
        i_rsp_ready = 1'b0;
        i_SResp     = SRESP_NULL;
        check({tag, "_done_rspv"},  64'(o_rsp_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(o_req_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] rsel;
        logic [1:0] resp;

        rst = 1'b1;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        run_txn("rd_fast", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 0, SRESP_DVA, 32'hDEAD_BEEF, 0);
        run_txn("wr_slow", 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 3, 2, SRESP_DVA, 32'hFFFF_FFFF, 0);
        run_txn("rd_err", 1'b0, 32'h0000_0080, 32'h0, 4'hF, 1, 1, SRESP_ERR, 32'hCAFE_F00D, 5);
        run_txn("wr_fail", 1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 4'h3, 0, 0, SRESP_FAIL, 32'h1, 1);

        // reset while the read command is still unaccepted
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0000_0200;
        step();
        i_req_valid = 1'b0;
        check("rstcmd_mcmd", 64'(o_MCmd), 64'(MCMD_RD));
        step();
        check("rstcmd_mcmd_hold", 64'(o_MCmd), 64'(MCMD_RD));
        rst = 1'b1;
        step();
        check_reset_vals("rstcmd");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_SResp      = SRESP_DVA;
            i_SData      = $urandom;
            i_SCmdAccept = 1'($urandom);
            step();
            check("stray_rspv",  64'(o_rsp_valid), 64'd0);
            check("stray_ready", 64'(o_req_ready), 64'd1);
            check("stray_mcmd",  64'(o_MCmd),      64'(MCMD_IDLE));
        end
        i_SResp      = SRESP_NULL;
        i_SCmdAccept = 1'b0;

        // randomized transactions
        for (int t = 0; t < 24; t++) begin
            rsel = 2'($urandom_range(0, 3));
            resp = (rsel < 2) ? SRESP_DVA : ((rsel == 2) ? SRESP_FAIL : SRESP_ERR);
            run_txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 2), resp, $urandom,
                    $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) step();
        end

`ifdef OCP_MASTER_TIMEOUT_EN
        // slave never accepts: abort exactly TMO cycles after command entry
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0000_0300;
        step();
        i_req_valid = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            check("tmo_cmd",  64'(o_MCmd),      64'(MCMD_RD));
            check("tmo_rspv", 64'(o_rsp_valid), 64'd0);
            step();
        end
        check("tmo_valid", 64'(o_rsp_valid), 64'd1);
        check("tmo_err",   64'(o_rsp_err),   64'd1);
        check("tmo_flag",  64'(o_rsp_tmo),   64'd1);
        check("tmo_data",  64'(o_rsp_data),  64'd0);
        check("tmo_mcmd",  64'(o_MCmd),      64'(MCMD_IDLE));
        i_SResp = SRESP_DVA;
        i_SData = 32'h5555_AAAA;
        step();
        check("tmo_late_data", 64'(o_rsp_data), 64'd0);
        check("tmo_late_flag", 64'(o_rsp_tmo),  64'd1);
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        check("tmo_done_ready", 64'(o_req_ready), 64'd1);
        step();
        check("tmo_idle_rspv", 64'(o_rsp_valid), 64'd0);
        i_SResp = SRESP_NULL;
`else
        // without the watchdog the command is held indefinitely
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h0000_0300;
        i_req_data  = 32'h0BAD_F00D;
        step();
        i_req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check("notmo_cmd",  64'(o_MCmd),      64'(MCMD_WR));
            check("notmo_rspv", 64'(o_rsp_valid), 64'd0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("notmo_rst");
`endif

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout_guard observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
